led_pixel_fetch: RTL
====================

// Module: led_pixel_fetch
// PURPOSE
//  Sits downstream of the LED blitter. Consumes its scan position (ctl_cur_x/y/bit, ctl_vsync), fetches RGB pixels from a
//  double-buffered framebuffer BRAM and drives the per-chain HUB75 data lines (upper and lower half-panel) bit-plane by bit-plane.
//  Two read ports (upper/lower half) give one pixel per chain per port per cycle. Data is committed before the blitter's led_clk rises.
// PARAMETERS
//  C_LED_CHAINS        4   number of display chains
//  C_LED_CHAIN_LENGTH  4   displays per chain
//  C_LED_NBANKS        16  banks (rows per half-panel)
//  C_LED_WIDTH         32  pixels per display row
//  C_LED_CLKDIV        16  sys_clk cycles per LED pixel (must match blitter)
//  C_BPC               12  bits per colour channel
//  C_MEM_LATENCY       2   BRAM read latency in sys_clk cycles (>=1)
//  Derived: XW=$clog2(C_LED_WIDTH*C_LED_CHAIN_LENGTH), YW=$clog2(C_LED_NBANKS), BW=$clog2(C_BPC), CW=max(1,$clog2(C_LED_CHAINS)), AW=1+CW+YW+1+XW
// PORTS
//  sys_clk     in   1                 system clock
//  sys_rst     in   1                 reset, asynchronous, active-low
//  ctl_cur_x   in   XW                blitter pixel column
//  ctl_cur_y   in   YW                blitter bank
//  ctl_cur_bit in   BW                blitter bit-plane
//  ctl_vsync   in   1                 blitter frame sync pulse
//  buf_sel     in   1                 requested display buffer (sw side)
//  buf_active  out  1                 buffer currently scanned
//  mem_en      out  1                 read strobe, both ports
//  mem_addr_a  out  AW                upper-half address {buf,chain,1'b0,y,x}
//  mem_addr_b  out  AW                lower-half address {buf,chain,1'b1,y,x}
//  mem_rdata_a in   3*C_BPC           upper pixel {R,G,B}
//  mem_rdata_b in   3*C_BPC           lower pixel {R,G,B}
//  led_rgb     out  6*C_LED_CHAINS    chain k bits [6k+5:6k] = {r0,g0,b0,r1,g1,b1}
//  fetch_busy  out  1                 fetch in progress
//  overrun     out  1                 sticky: position changed mid-fetch
//  overrun_clr in   1                 synchronous clear of overrun
// BEHAVIOUR
//  - Reset: buf_active=0, mem_en=0, addresses=0, led_rgb=0, fetch_busy=0, overrun=0, FSM=IDLE, force_fetch=1.
//  - Trigger: edge where tuple {x,y,bit} != last latched tuple, or force_fetch=1. Tuple and buf_active latched; force_fetch cleared.
//  - FSM: IDLE -trigger-> ISSUE (chain idx 0..C_LED_CHAINS-1, one per cycle, mem_en=1) -> DRAIN (C_MEM_LATENCY cycles)
//    -> COMMIT (staging -> led_rgb in one edge) -> IDLE. fetch_busy=1 in all states except IDLE.
//  - mem_en/mem_addr_* are registered. Chain k's address is valid in cycle k+1 after trigger. rdata is sampled C_MEM_LATENCY cycles
//    after its address was presented, tagged by a valid/chain shift register.
//  - led_rgb changes at edge C_LED_CHAINS+C_MEM_LATENCY+1 after trigger (7 at defaults) and holds otherwise, all chains atomically.
//  - Bit select: r0=R_a[bit], g0=G_a[bit], b0=B_a[bit]; r1/g1/b1 from port b. bit >= C_BPC yields 0.
//  - Timing constraint: C_LED_CHAINS+C_MEM_LATENCY+1 <= C_LED_CLKDIV/2, checked at elaboration ($error).
//  - Tuple change while busy: overrun<=1. Fetch restarts in ISSUE at chain 0 with new tuple. Valid pipe flushed, so in-flight data is
//    dropped. led_rgb keeps the old value until the restarted fetch commits.
//  - overrun_clr and a new overrun on the same edge: set wins.
//  - Buffer swap: buf_sel sampled on rising edge of ctl_vsync (registered edge detect) -> buf_active. Never changes mid-fetch:
//    the fetch uses the value latched at trigger.
//  - x wrap (max->0 at line end) is an ordinary tuple change.
// CONFIGURATION
//  LED_FETCH_TESTPAT_EN defined: adds input test_en (1 bit). When 1, read data is replaced by a generated pixel:
//  R = latched x, G = latched y, B = chain index. Each value is zero-extended or truncated to C_BPC.
//  Memory reads and timing are unchanged. When 0, memory data is used.
//  LED_FETCH_TESTPAT_EN undefined: no test_en port; memory data always used.
// TESTING
//  1 Reset release, BRAM model latency 2, x=0,y=0,bit=0 -> forced fetch; mem_en high 4 cycles, led_rgb valid at edge 7, fetch_busy low after.
//  2 Chain 2 upper pixel R=12'h001, lower B=12'h800; step bit 0->11 -> led_rgb[17]=1 at bit 0 only; led_rgb[12]=1 at bit 11 only.
//  3 Change x at cycle 3 of a fetch -> overrun=1, addresses restart at chain 0 with new x, led_rgb matches new x 7 edges later.
//    overrun_clr -> overrun=0.
//  4 buf_sel=1 mid-frame -> addresses keep bit AW-1=0 until ctl_vsync rises, then buf_active=1 and next fetch addr MSB=1.
//  5 Full blitter+fetch sim, defaults, 1 frame -> zero overruns; every led_clk rising edge sees led_rgb stable >=1 cycle.
//  6 With LED_FETCH_TESTPAT_EN and test_en=1, x=5,y=3,bit=0 -> chain 1 bits {r0,g0,b0,r1,g1,b1}=6'b111111.

Source files
------------

// File: rtl/led_pixel_fetch.sv
// HUB75 pixel fetch: turns the blitter scan position into per-chain RGB bit-plane data read from a double-buffered framebuffer.
// Optional LED_FETCH_TESTPAT_EN adds test_en, which replaces read data with a generated {x, y, chain} pattern.
module led_pixel_fetch #(
  parameter int C_LED_CHAINS       = 4,
  parameter int C_LED_CHAIN_LENGTH = 4,
  parameter int C_LED_NBANKS       = 16,
  parameter int C_LED_WIDTH        = 32,
  parameter int C_LED_CLKDIV       = 16,
  parameter int C_BPC              = 12,
  parameter int C_MEM_LATENCY      = 2,
  localparam int XW = $clog2(C_LED_WIDTH * C_LED_CHAIN_LENGTH),
  localparam int YW = $clog2(C_LED_NBANKS),
  localparam int BW = $clog2(C_BPC),
  localparam int CW = (C_LED_CHAINS > 1) ? $clog2(C_LED_CHAINS) : 1,
  localparam int AW = 1 + CW + YW + 1 + XW
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [XW-1:0]             ctl_cur_x,
  input  logic [YW-1:0]             ctl_cur_y,
  input  logic [BW-1:0]             ctl_cur_bit,
  input  logic                      ctl_vsync,
  input  logic                      buf_sel,
  output logic                      buf_active,
  output logic                      mem_en,
  output logic [AW-1:0]             mem_addr_a,
  output logic [AW-1:0]             mem_addr_b,
  input  logic [3*C_BPC-1:0]        mem_rdata_a,
  input  logic [3*C_BPC-1:0]        mem_rdata_b,
`ifdef LED_FETCH_TESTPAT_EN
  input  logic                      test_en,
`endif
  output logic [6*C_LED_CHAINS-1:0] led_rgb,
  output logic                      fetch_busy,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  localparam int DW = (C_MEM_LATENCY > 1) ? $clog2(C_MEM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LP_LAST_CHAIN = CW'(C_LED_CHAINS - 1);
  localparam logic [DW-1:0] LP_LAST_DRAIN = DW'(C_MEM_LATENCY - 1);

  if (C_MEM_LATENCY < 1) begin : g_lat_chk
    $error("led_pixel_fetch: C_MEM_LATENCY must be at least 1");
  end
  if (C_LED_CHAINS + C_MEM_LATENCY + 1 > C_LED_CLKDIV / 2) begin : g_timing_chk
    $error("led_pixel_fetch: fetch does not complete within half an LED clock period");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT} state_t;

  state_t                    r_state;
  logic [XW-1:0]             r_x;
  logic [YW-1:0]             r_y;
  logic [BW-1:0]             r_bit;
  logic                      r_force;
  logic                      r_fetch_buf;
  logic                      r_buf_active;
  logic                      r_vsync_d;
  logic [CW-1:0]             r_idx;
  logic [DW-1:0]             r_drain;
  logic [AW-1:0]             r_addr_a;
  logic [AW-1:0]             r_addr_b;
  logic [C_MEM_LATENCY-1:0]  r_pv;
  logic [CW-1:0]             r_pc [C_MEM_LATENCY];
  logic [6*C_LED_CHAINS-1:0] r_stage;
  logic [6*C_LED_CHAINS-1:0] r_led;
  logic                      r_busy;
  logic                      r_overrun;

  logic                      w_tuple_chg;
  logic                      w_vsync_rise;
  logic                      w_ovr_set;
  logic                      w_smp_vld;
  logic [CW-1:0]             w_smp_chain;
  logic [3*C_BPC-1:0]        w_pix_a;
  logic [3*C_BPC-1:0]        w_pix_b;
  logic [5:0]                w_six;

  function automatic logic bit_of(input logic [C_BPC-1:0] v, input logic [BW-1:0] b);
    return (32'(b) < C_BPC) ? v[b] : 1'b0;
  endfunction

  assign w_tuple_chg  = {ctl_cur_x, ctl_cur_y, ctl_cur_bit} != {r_x, r_y, r_bit};
  assign w_vsync_rise = ctl_vsync & ~r_vsync_d;
  assign w_ovr_set    = (r_state != S_IDLE) && w_tuple_chg;
  assign w_smp_vld    = r_pv[C_MEM_LATENCY-1];
  assign w_smp_chain  = r_pc[C_MEM_LATENCY-1];

`ifdef LED_FETCH_TESTPAT_EN
  assign w_pix_a = test_en ? {C_BPC'(r_x), C_BPC'(r_y), C_BPC'(w_smp_chain)} : mem_rdata_a;
  assign w_pix_b = test_en ? {C_BPC'(r_x), C_BPC'(r_y), C_BPC'(w_smp_chain)} : mem_rdata_b;
`else
  assign w_pix_a = mem_rdata_a;
  assign w_pix_b = mem_rdata_b;
`endif

  assign w_six = {bit_of(w_pix_a[3*C_BPC-1:2*C_BPC], r_bit),
                  bit_of(w_pix_a[2*C_BPC-1:C_BPC], r_bit),
                  bit_of(w_pix_a[C_BPC-1:0], r_bit),
                  bit_of(w_pix_b[3*C_BPC-1:2*C_BPC], r_bit),
                  bit_of(w_pix_b[2*C_BPC-1:C_BPC], r_bit),
                  bit_of(w_pix_b[C_BPC-1:0], r_bit)};

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_bit        <= '0;
      r_force      <= 1'b1;
      r_fetch_buf  <= 1'b0;
      r_buf_active <= 1'b0;
      r_vsync_d    <= 1'b0;
      r_idx        <= '0;
      r_drain      <= '0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_pv         <= '0;
      for (int i = 0; i < C_MEM_LATENCY; i++) r_pc[i] <= '0;
      r_stage      <= '0;
      r_led        <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_vsync_d <= ctl_vsync;
      if (w_vsync_rise) r_buf_active <= buf_sel;

      r_overrun <= w_ovr_set | (r_overrun & ~overrun_clr);

      // Tag pipe mirrors the BRAM latency so each returning word knows its chain.
      for (int i = C_MEM_LATENCY - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
      end
      r_pv[0] <= 1'b0;

      for (int k = 0; k < C_LED_CHAINS; k++) begin
        if (w_smp_vld && (w_smp_chain == CW'(k))) r_stage[6*k +: 6] <= w_six;
      end

      if (r_state == S_IDLE) begin
        if (w_tuple_chg || r_force) begin
          r_x         <= ctl_cur_x;
          r_y         <= ctl_cur_y;
          r_bit       <= ctl_cur_bit;
          r_fetch_buf <= r_buf_active;
          r_force     <= 1'b0;
          r_idx       <= '0;
          r_busy      <= 1'b1;
          r_state     <= S_ISSUE;
        end
      end else if (w_tuple_chg) begin
        // Restart with the new position; anything still in flight belongs to the stale one.
        r_x         <= ctl_cur_x;
        r_y         <= ctl_cur_y;
        r_bit       <= ctl_cur_bit;
        r_fetch_buf <= r_buf_active;
        r_idx       <= '0;
        r_pv        <= '0;
        r_state     <= S_ISSUE;
      end else begin
        case (r_state)
          S_ISSUE: begin
            r_pv[0]  <= 1'b1;
            r_pc[0]  <= r_idx;
            r_addr_a <= {r_fetch_buf, r_idx, 1'b0, r_y, r_x};
            r_addr_b <= {r_fetch_buf, r_idx, 1'b1, r_y, r_x};
            if (r_idx == LP_LAST_CHAIN) begin
              r_drain <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          S_DRAIN: begin
            if (r_drain == LP_LAST_DRAIN) r_state <= S_COMMIT;
            else                          r_drain <= r_drain + 1'b1;
          end
          S_COMMIT: begin
            r_led   <= r_stage;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign buf_active = r_buf_active;
  assign mem_en     = r_pv[0];
  assign mem_addr_a = r_addr_a;
  assign mem_addr_b = r_addr_b;
  assign led_rgb    = r_led;
  assign fetch_busy = r_busy;
  assign overrun    = r_overrun;

endmodule
